// File: rtl/deco_exe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// deco_exe_stage_reg_pkg
// Shared types for the decode->execute pipeline register:
//   deco_exe_cu_signals : control-unit bundle carried from decode into EX
//   CU_NOP_BUNDLE       : all-zero bundle used for bubbles and reset
//   trig_state_t        : state encoding of the trig occupancy FSM
// -----------------------------------------------------------------------------
package deco_exe_stage_reg_pkg;

    typedef struct packed {
        logic [3:0] aluControl;
        logic       trigControl;  // SIN/COS op, occupies EX for several cycles
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
    } deco_exe_cu_signals;

    localparam deco_exe_cu_signals CU_NOP_BUNDLE = '0;

    typedef enum logic [1:0] {
        TRIG_IDLE = 2'd0,
        TRIG_BUSY = 2'd1,
        TRIG_DONE = 2'd2
    } trig_state_t;

endpackage

// File: rtl/deco_exe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// deco_exe_stage_reg_if
// Bundles the decode-side payload (inputs to the stage register) and the
// EX-side registered payload (outputs of the stage register).
//   master : the decode stage / environment (drives *_i, observes *_o)
//   slave  : the stage register (observes *_i, drives *_o)
//
// Handshake: de_valid_i qualifies the decode payload in the cycle it is high.
// The register accepts it on a rising edge only when no flush, no stall and no
// trig occupancy is active (trig_busy_o low); otherwise decode must hold it.
// ex_valid_o qualifies the EX payload and has no ready of its own: EX always
// consumes what the register presents.
// -----------------------------------------------------------------------------
interface deco_exe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) ();
    import deco_exe_stage_reg_pkg::*;

    // decode side
    logic               de_valid_i;
    deco_exe_cu_signals cu_i;
    logic [DATA_W-1:0]  rd1_i;
    logic [DATA_W-1:0]  rd2_i;
    logic [DATA_W-1:0]  imm_i;
    logic [REG_AW-1:0]  rd_addr_i;
    logic [DATA_W-1:0]  pc_i;

    // execute side
    logic               ex_valid_o;
    deco_exe_cu_signals cu_o;
    logic [DATA_W-1:0]  rd1_o;
    logic [DATA_W-1:0]  rd2_o;
    logic [DATA_W-1:0]  imm_o;
    logic [REG_AW-1:0]  rd_addr_o;
    logic [DATA_W-1:0]  pc_o;

    modport master (
        output de_valid_i, cu_i, rd1_i, rd2_i, imm_i, rd_addr_i, pc_i,
        input  ex_valid_o, cu_o, rd1_o, rd2_o, imm_o, rd_addr_o, pc_o
    );

    modport slave (
        input  de_valid_i, cu_i, rd1_i, rd2_i, imm_i, rd_addr_i, pc_i,
        output ex_valid_o, cu_o, rd1_o, rd2_o, imm_o, rd_addr_o, pc_o
    );

endinterface

// File: rtl/deco_exe_stage_reg_trig_occupancy_fsm.sv
// -----------------------------------------------------------------------------
// trig_occupancy_fsm
// Keeps a trig op resident in EX for TRIG_LAT cycles: TRIG_LAT-1 BUSY cycles
// followed by one DONE cycle.
//   clk, rst_n : clock, async active-low reset
//   i_flush    : abort any in-flight op, return to IDLE
//   i_start    : a valid trig op is being loaded into EX this edge
//   o_busy     : Moore decode of BUSY, back-pressures decode/fetch
//   o_done     : Moore decode of DONE, write-back enable for the trig result
//   o_state    : current state for observation
// TRIG_LAT must be >= 2.
// -----------------------------------------------------------------------------
module trig_occupancy_fsm
    import deco_exe_stage_reg_pkg::*;
#(
    parameter int TRIG_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output trig_state_t o_state
);

    localparam int CNT_W = $clog2(TRIG_LAT);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(TRIG_LAT - 2);

    trig_state_t      r_state;
    trig_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TRIG_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_flush) begin
            w_state_nxt = TRIG_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                // DONE accepts a new load like IDLE does, so a trig op loaded
                // on the DONE edge still gets its full occupancy.
                TRIG_IDLE, TRIG_DONE: begin
                    if (i_start) begin
                        w_state_nxt = TRIG_BUSY;
                        w_cnt_nxt   = CNT_START;
                    end else begin
                        w_state_nxt = TRIG_IDLE;
                    end
                end
                // Counts regardless of the hazard stall.
                TRIG_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = TRIG_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = TRIG_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_busy  = (r_state == TRIG_BUSY);
    assign o_done  = (r_state == TRIG_DONE);
    assign o_state = r_state;

endmodule

// File: rtl/deco_exe_stage_reg.sv
// -----------------------------------------------------------------------------
// deco_exe_stage_reg
// Decode->execute pipeline register with flush (bubble), stall (hold) and
// multi-cycle occupancy for trig ops.
//   clk, rst_n   : clock, async active-low reset
//   stall_i      : hazard stall, hold EX contents
//   flush_i      : branch flush, load a bubble (highest priority)
//   bus (slave)  : decode payload in, registered EX payload out
//   trig_busy_o  : trig op occupying EX, decode must hold
//   trig_done_o  : last EX cycle of a trig op
//   o_dbg_state  : trig FSM state
// Update priority per edge: flush > (stall | trig_busy) > load.
// -----------------------------------------------------------------------------
module deco_exe_stage_reg
    import deco_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int TRIG_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 flush_i,
    deco_exe_stage_reg_if.slave  bus,
    output logic                 trig_busy_o,
    output logic                 trig_done_o,
    output trig_state_t          o_dbg_state
);

    deco_exe_cu_signals r_cu;
    logic [DATA_W-1:0]  r_rd1;
    logic [DATA_W-1:0]  r_rd2;
    logic [DATA_W-1:0]  r_imm;
    logic [REG_AW-1:0]  r_rd_addr;
    logic [DATA_W-1:0]  r_pc;
    logic               r_ex_valid;

    logic w_load;
    logic w_bubble;
    logic w_trig_start;

    assign w_load       = !flush_i && !(stall_i || trig_busy_o);
    // An invalid decode slot loads as a bubble even if its bundle looks like
    // a trig op, so garbage can never start the occupancy FSM.
    assign w_bubble     = flush_i || (w_load && !bus.de_valid_i);
    assign w_trig_start = w_load && bus.de_valid_i && bus.cu_i.trigControl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cu       <= CU_NOP_BUNDLE;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rd_addr  <= '0;
            r_pc       <= '0;
            r_ex_valid <= 1'b0;
        end else if (w_bubble) begin
            r_cu       <= CU_NOP_BUNDLE;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rd_addr  <= '0;
            r_pc       <= '0;
            r_ex_valid <= 1'b0;
        end else if (w_load) begin
            r_cu       <= bus.cu_i;
            r_rd1      <= bus.rd1_i;
            r_rd2      <= bus.rd2_i;
            r_imm      <= bus.imm_i;
            r_rd_addr  <= bus.rd_addr_i;
            r_pc       <= bus.pc_i;
            r_ex_valid <= 1'b1;
        end
    end

    assign bus.cu_o       = r_cu;
    assign bus.rd1_o      = r_rd1;
    assign bus.rd2_o      = r_rd2;
    assign bus.imm_o      = r_imm;
    assign bus.rd_addr_o  = r_rd_addr;
    assign bus.pc_o       = r_pc;
    assign bus.ex_valid_o = r_ex_valid;

    trig_occupancy_fsm #(
        .TRIG_LAT (TRIG_LAT)
    ) u_trig_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush_i),
        .i_start (w_trig_start),
        .o_busy  (trig_busy_o),
        .o_done  (trig_done_o),
        .o_state (o_dbg_state)
    );

endmodule

// File: tb/tb_deco_exe_stage_reg.sv
module tb_deco_exe_stage_reg;
  import deco_exe_stage_reg_pkg::*;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int TRIG_LAT = 4;

  typedef struct packed {
    deco_exe_cu_signals cu;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  pc;
  } payload_t;

  // {state, busy, done, ex_valid, payload}
  localparam int EXP_W = 5 + $bits(payload_t);

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        trig_busy_o;
  logic        trig_done_o;
  trig_state_t dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  deco_exe_stage_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  deco_exe_stage_reg #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .TRIG_LAT (TRIG_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .bus         (bus),
    .trig_busy_o (trig_busy_o),
    .trig_done_o (trig_done_o),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic set_in(input logic v, input payload_t p);
    bus.de_valid_i = v;
    bus.cu_i       = p.cu;
    bus.rd1_i      = p.rd1;
    bus.rd2_i      = p.rd2;
    bus.imm_i      = p.imm;
    bus.rd_addr_i  = p.rd;
    bus.pc_i       = p.pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic deco_exe_cu_signals mk_cu(input logic [3:0] alu, input logic trig);
    deco_exe_cu_signals c;
    c = CU_NOP_BUNDLE;
    c.aluControl  = alu;
    c.trigControl = trig;
    c.regWrite    = 1'b1;
    return c;
  endfunction

  function automatic payload_t rand_payload(input logic trig);
    payload_t p;
    p.cu             = deco_exe_cu_signals'($urandom_range(0, 2047));
    p.cu.trigControl = trig;
    p.rd1            = $urandom;
    p.rd2            = $urandom;
    p.imm            = $urandom;
    p.rd             = REG_AW'($urandom_range(0, 15));
    p.pc             = $urandom;
    return p;
  endfunction

  function automatic logic [EXP_W-1:0] exp_pack(input trig_state_t st, input logic busy,
                                                input logic done, input logic v,
                                                input payload_t p);
    return {st, busy, done, v, p};
  endfunction

  function automatic logic [EXP_W-1:0] act_pack();
    payload_t p;
    p.cu  = bus.cu_o;
    p.rd1 = bus.rd1_o;
    p.rd2 = bus.rd2_o;
    p.imm = bus.imm_o;
    p.rd  = bus.rd_addr_o;
    p.pc  = bus.pc_o;
    return {dbg_state, trig_busy_o, trig_done_o, bus.ex_valid_o, p};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EXP_W-1:0] act, exp;
    payload_t p;
    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_in(1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
    act = act_pack(); exp = exp_q.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", act, exp);
    end

    rst_n = 1'b1;
    p.cu = mk_cu(4'b0010, 1'b0); p.rd1 = 32'hAA; p.rd2 = 32'hBB;
    p.imm = 32'hCC; p.rd = 4'd9; p.pc = 32'h44;
    set_in(1'b1, p);
    exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, p));
    tick();
    act = act_pack(); exp = exp_q.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL reset_release_load: got %h expected %h", act, exp);
    end

    // Asynchronous assertion between edges: outputs clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
    act = act_pack(); exp = exp_q.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", act, exp);
    end
    tick();
    rst_n = 1'b1;
    set_in(1'b0, '0);
  endtask

  task automatic test_add_load();
    logic [EXP_W-1:0] act, exp;
    payload_t p;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        p.cu = mk_cu(4'b0010, 1'b0); p.rd1 = 32'd5; p.rd2 = 32'd7;
        p.imm = 32'h10; p.rd = 4'd3; p.pc = 32'h100;
        set_in(1'b1, p);
        exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, p));
      end else if (i == 1) begin
        // invalid slot with live-looking data loads a bubble
        p = rand_payload(1'b0);
        set_in(1'b0, p);
        exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
      end else begin
        p = rand_payload(1'b0);
        set_in(1'b1, p);
        exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, p));
      end
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL add_load[%0d]: got %h expected %h", i, act, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [EXP_W-1:0] act, exp;
    payload_t a, b;
    a = rand_payload(1'b0);
    b = rand_payload(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        stall_i = 1'b0;
        set_in(1'b1, a);
        exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, a));
      end else if (i < 4) begin
        stall_i = 1'b1;
        set_in(1'($urandom_range(0, 1)), rand_payload(1'($urandom_range(0, 1))));
        exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, a));
      end else begin
        stall_i = 1'b0;
        set_in(1'b1, b);
        exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, b));
      end
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %h expected %h", i, act, exp);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_trig();
    logic [EXP_W-1:0] act, exp;
    payload_t s, n;
    s = rand_payload(1'b1);
    n = rand_payload(1'b0);
    // TRIG_LAT=4: three BUSY cycles, one DONE cycle, next op loads on the DONE edge
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_in(1'b1, s);
      else if (i < 4) set_in(1'b1, rand_payload(1'($urandom_range(0, 1))));
      else if (i == 4) set_in(1'b1, n);
      else set_in(1'b0, '0);
      if (i < 3)       exp_q.push_back(exp_pack(TRIG_BUSY, 1'b1, 1'b0, 1'b1, s));
      else if (i == 3) exp_q.push_back(exp_pack(TRIG_DONE, 1'b0, 1'b1, 1'b1, s));
      else if (i == 4) exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, n));
      else             exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL trig_sin[%0d]: got %h expected %h", i, act, exp);
      end
    end
  endtask

  task automatic test_trig_stall();
    logic [EXP_W-1:0] act, exp;
    payload_t s, n;
    s = rand_payload(1'b1);
    n = rand_payload(1'b0);
    // hazard stall held through BUSY and DONE: counter and DONE->IDLE still advance
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        stall_i = 1'b0; set_in(1'b1, s);
      end else if (i < 5) begin
        stall_i = 1'b1; set_in(1'b1, rand_payload(1'b0));
      end else begin
        stall_i = 1'b0; set_in(1'b1, n);
      end
      if (i < 3)       exp_q.push_back(exp_pack(TRIG_BUSY, 1'b1, 1'b0, 1'b1, s));
      else if (i == 3) exp_q.push_back(exp_pack(TRIG_DONE, 1'b0, 1'b1, 1'b1, s));
      else if (i == 4) exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, s));
      else             exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, n));
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL trig_stall[%0d]: got %h expected %h", i, act, exp);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_flush_busy();
    logic [EXP_W-1:0] act, exp;
    payload_t s, n;
    s = rand_payload(1'b1);
    n = rand_payload(1'b0);
    for (int i = 0; i < 6; i++) begin
      flush_i = (i == 1);
      if (i == 0)      set_in(1'b1, s);
      else if (i == 1) set_in(1'b1, rand_payload(1'b0));
      else if (i == 2) set_in(1'b1, n);
      else             set_in(1'b0, '0);
      if (i == 0)      exp_q.push_back(exp_pack(TRIG_BUSY, 1'b1, 1'b0, 1'b1, s));
      else if (i == 2) exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, n));
      else             exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL flush_busy[%0d]: got %h expected %h", i, act, exp);
      end
    end
    flush_i = 1'b0;
  endtask

  task automatic test_flush_stall();
    logic [EXP_W-1:0] act, exp;
    payload_t a, a2;
    a  = rand_payload(1'b0);
    a2 = rand_payload(1'b0);
    for (int i = 0; i < 5; i++) begin
      flush_i = (i == 1);
      stall_i = (i == 1) || (i == 3);
      if (i == 0)      set_in(1'b1, a);
      else if (i == 1) set_in(1'b1, rand_payload(1'b0));
      else if (i == 2) set_in(1'b0, rand_payload(1'b1));
      else if (i == 3) set_in(1'b1, rand_payload(1'b1));
      else             set_in(1'b1, a2);
      if (i == 0)      exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, a));
      else if (i == 4) exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, a2));
      else             exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL flush_stall[%0d]: got %h expected %h", i, act, exp);
      end
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [EXP_W-1:0] act, exp;
    payload_t p;
    logic v;
    for (int i = 0; i < 10; i++) begin
      p = rand_payload(1'b0);
      v = 1'($urandom_range(0, 1));
      set_in(v, p);
      if (v) exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b1, p));
      else   exp_q.push_back(exp_pack(TRIG_IDLE, 1'b0, 1'b0, 1'b0, '0));
      tick();
      act = act_pack(); exp = exp_q.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, act, exp);
      end
    end
    set_in(1'b0, '0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add_load();
    test_stall();
    test_trig();
    test_trig_stall();
    test_flush_busy();
    test_flush_stall();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
